// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nibble_serial_add_ctrl_pkg: state encoding, slice width and overflow helper for the serial nibble adder.
package nibble_serial_add_ctrl_pkg;
    localparam int NIBBLE_W = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: request/result bundle between the requester and the serial adder.
interface nibble_serial_add_ctrl_if
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIBBLE_W * NIBBLES;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    modport master (output start, a, b, cin, input ready, busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout, ovf);
endinterface

// File: rtl/nibble_serial_add_ctrl_nibble_add4.sv
// nibble_serial_add_ctrl_nibble_add4: the single shared combinational 4-bit adder slice.
module nibble_serial_add_ctrl_nibble_add4
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4_i,
    input  logic [NIBBLE_W-1:0] b4_i,
    input  logic                ci_i,
    output logic [NIBBLE_W-1:0] s4_o,
    output logic                co_o
);
    assign {co_o, s4_o} = {1'b0, a4_i} + {1'b0, b4_i} + (NIBBLE_W + 1)'(ci_i);
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: runs a W-bit add LSB-first one nibble per cycle through one shared 4-bit adder.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic                     clk,
    input logic                     rst,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    state_e              state_q;
    logic [IW-1:0]       idx_q;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [W-1:0]        sum_q;
    logic                carry_q;
    logic                cout_q;
    logic                ovf_q;
    logic [NIBBLE_W-1:0] a4;
    logic [NIBBLE_W-1:0] b4;
    logic [NIBBLE_W-1:0] s4;
    logic                co;
    logic                accept;
    logic                last;
    // Slice select by shifting the latched operands down by 4*idx.
    assign a4     = NIBBLE_W'(a_q >> {idx_q, 2'b00});
    assign b4     = NIBBLE_W'(b_q >> {idx_q, 2'b00});
    assign last   = idx_q == IW'(NIBBLES - 1);
    assign accept = bus.start && (state_q != S_RUN);
    nibble_serial_add_ctrl_nibble_add4 u_add4 (
        .a4_i (a4),
        .b4_i (b4),
        .ci_i (carry_q),
        .s4_o (s4),
        .co_o (co)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == S_RUN) begin
            sum_q[{idx_q, 2'b00} +: NIBBLE_W] <= s4;
            carry_q <= co;
            idx_q   <= last ? '0 : idx_q + 1'b1;
            if (last) begin
                state_q <= S_DONE;
                cout_q  <= co;
                ovf_q   <= signed_ovf(a_q[W-1], b_q[W-1], s4[NIBBLE_W-1]);
            end
        end else begin
            state_q <= S_IDLE;
        end
    end
    assign bus.ready = state_q != S_RUN;
    assign bus.busy  = state_q == S_RUN;
    assign bus.done  = state_q == S_DONE;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed ops checked against an arithmetic reference model and literal results.
module tb_nibble_serial_add_ctrl;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int SMAX = 2 ** (W - 1) - 1;
    localparam int SMIN = -(2 ** (W - 1));
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();
    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Reference: an op is a countdown of N busy cycles, then the plain arithmetic result.
    int           m_cnt   = 0;
    int           m_s     = 0;
    bit           m_valid = 1'b0;
    bit           m_done  = 1'b0;
    bit           m_cout  = 1'b0;
    bit           m_ovf   = 1'b0;
    bit           p_ovf   = 1'b0;
    logic [W-1:0] m_sum   = '0;
    logic [W:0]   p_full  = '0;
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_cnt   = 0;
            m_done  = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (bus.start && m_cnt == 0) begin
            p_full = {1'b0, bus.a} + {1'b0, bus.b} + (W + 1)'(bus.cin);
            m_s    = int'($signed(bus.a)) + int'($signed(bus.b)) + int'(bus.cin);
            p_ovf  = (m_s > SMAX) || (m_s < SMIN);
            m_cnt  = N;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                m_sum  = p_full[W-1:0];
                m_cout = p_full[W];
                m_ovf  = p_ovf;
            end
        end else begin
            m_done = 1'b0;
        end
    end
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready", 32'(bus.ready), 32'(m_cnt == 0));
            chk("busy", 32'(bus.busy), 32'(m_cnt > 0));
            chk("done", 32'(bus.done), 32'(m_done));
            if (m_cnt == 0) begin
                chk("sum", 32'(bus.sum), 32'(m_sum));
                chk("cout", 32'(bus.cout), 32'(m_cout));
                chk("ovf", 32'(bus.ovf), 32'(m_ovf));
            end
        end
    end
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 1;
        busy_n = 0;
        while (!bus.done && lat < 20) begin
            busy_n += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          output int lat, output int busy_n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'b1;
        wait_done(lat, busy_n);
    endtask
    task automatic op_chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int lat, bn;
        run_op(a, b, ci, lat, bn);
        chk({nm, "_lat"}, 32'(lat), 32'd5);
        chk({nm, "_sum"}, 32'(bus.sum), 32'(es));
        chk({nm, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'(eo));
    endtask
    initial begin
        int lat, bn, nd;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        run_op(16'h1234, 16'h4321, 1'b0, lat, bn);
        chk("t1_lat", 32'(lat), 32'd5);
        chk("t1_busy_cycles", 32'(bn), 32'd4);
        chk("t1_sum", 32'(bus.sum), 32'h5555);
        op_chk("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op_chk("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op_chk("t3b", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        op_chk("t3c", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        op_chk("t3d", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        // Start pulsed mid-op must be dropped, not queued.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h2222;
        bus.b     = 16'h3333;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            nd += int'(bus.done);
        end
        chk("t4_done_pulses", 32'(nd), 32'd1);
        chk("t4_sum", 32'(bus.sum), 32'h5555);
        // Reset in the second RUN cycle discards the op.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h4321;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_ready", 32'(bus.ready), 32'd1);
        chk("t5_sum", 32'(bus.sum), 32'd0);
        chk("t5_cout", 32'(bus.cout), 32'd0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            nd += int'(bus.done);
        end
        chk("t5_no_done", 32'(nd), 32'd0);
        op_chk("t5_after", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
        // Start held through DONE re-enters RUN with no idle bubble.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h4321;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.a     = 16'h0F0F;
        bus.b     = 16'h00F1;
        wait_done(lat, bn);
        chk("t6_first_lat", 32'(lat), 32'd5);
        chk("t6_first_sum", 32'(bus.sum), 32'h5555);
        @(negedge clk);
        chk("t6_b2b_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(lat, bn);
        chk("t6_lat", 32'(lat), 32'd5);
        chk("t6_sum", 32'(bus.sum), 32'h1000);
        chk("t6_cout", 32'(bus.cout), 32'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
